// File: rtl/crossbar_buffered_if.sv
// Switch-side bus of the buffered crossbar: allocator request signals in,
// per-output FIFO head, valid and full out, plus downstream ready.
interface crossbar_buffered_if #(
   parameter int INPUT_NUM  = 4,
   parameter int OUTPUT_NUM = 4,
   parameter int FLIT_SIZE  = 4
);
   localparam int SEL_SIZE = $clog2(INPUT_NUM);

   logic [INPUT_NUM-1:0][FLIT_SIZE-1:0]  data_i;
   logic [INPUT_NUM-1:0]                 valid_i;
   logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]  sel_i;
   logic [OUTPUT_NUM-1:0]                en_i;
   logic [OUTPUT_NUM-1:0][FLIT_SIZE-1:0] data_o;
   logic [OUTPUT_NUM-1:0]                valid_o;
   logic [OUTPUT_NUM-1:0]                ready_i;
   logic [OUTPUT_NUM-1:0]                full_o;

   modport master (
      output data_i, valid_i, sel_i, en_i, ready_i,
      input  data_o, valid_o, full_o
   );

   modport slave (
      input  data_i, valid_i, sel_i, en_i, ready_i,
      output data_o, valid_o, full_o
   );
endinterface

// File: rtl/crossbar_buffered.sv
// Buffered switch crossbar: each output selects one input flit into its own
// circular FIFO, drained by a valid/ready handshake with the output link.
module crossbar_buffered #(
   parameter int INPUT_NUM   = 4,
   parameter int OUTPUT_NUM  = 4,
   parameter int FLIT_SIZE   = 4,
   parameter int BUFFER_SIZE = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   crossbar_buffered_if.slave   bus
);
   localparam int SEL_SIZE = $clog2(INPUT_NUM);
   localparam int PTR_W    = $clog2(BUFFER_SIZE);
   localparam int CNT_W    = PTR_W + 1;
   localparam logic [SEL_SIZE:0] SEL_LIMIT = (SEL_SIZE + 1)'(INPUT_NUM);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUFFER_SIZE);

   for (genvar o = 0; o < OUTPUT_NUM; o++) begin : g_out
      logic [FLIT_SIZE-1:0] mem_r [BUFFER_SIZE];
      logic [PTR_W-1:0]     rd_ptr_r;
      logic [PTR_W-1:0]     wr_ptr_r;
      logic [CNT_W-1:0]     count_r;
      logic [FLIT_SIZE-1:0] wr_data_s;
      logic                 full_s;
      logic                 empty_s;
      logic                 push_s;
      logic                 pop_s;

      // Full/empty come from the pre-pop count, so a full FIFO refuses a push even while popping.
      assign full_s  = (count_r == CNT_FULL);
      assign empty_s = (count_r == {CNT_W{1'b0}});

      // Write/read qualification for this output.
      always_comb begin
         push_s    = 1'b0;
         pop_s     = 1'b0;
         wr_data_s = {FLIT_SIZE{1'b0}};
         if ({1'b0, bus.sel_i[o]} < SEL_LIMIT) begin
            wr_data_s = bus.data_i[bus.sel_i[o]];
            push_s    = bus.en_i[o] && bus.valid_i[bus.sel_i[o]] && !full_s;
         end else begin
            push_s    = 1'b0;
         end
         if (!empty_s && bus.ready_i[o]) begin
            pop_s = 1'b1;
         end else begin
            pop_s = 1'b0;
         end
      end

      // Flit storage; contents need no reset since count gates every read.
      always_ff @(posedge clk) begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data_s;
         end
      end

      // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
         end else begin
            if (push_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + CNT_W'(1);
               2'b01:   count_r <= count_r - CNT_W'(1);
               default: count_r <= count_r;
            endcase
         end
      end

      // Outputs decode state registers only; an empty FIFO shows zero, not the stale head.
      assign bus.valid_o[o] = !empty_s;
      assign bus.full_o[o]  = full_s;
      assign bus.data_o[o]  = empty_s ? {FLIT_SIZE{1'b0}} : mem_r[rd_ptr_r];
   end
endmodule

// File: tb/tb_crossbar_buffered.sv
// Randomized self-checking bench for crossbar_buffered against a queue-per-output
// reference model, plus directed reset, multicast and backpressure scenarios.
module tb_crossbar_buffered;
   localparam int IN  = 4;
   localparam int OUT = 4;
   localparam int FW  = 4;
   localparam int BS  = 2;
   localparam int SW  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   crossbar_buffered_if #(.INPUT_NUM(IN), .OUTPUT_NUM(OUT), .FLIT_SIZE(FW)) bus ();

   crossbar_buffered #(
      .INPUT_NUM(IN), .OUTPUT_NUM(OUT), .FLIT_SIZE(FW), .BUFFER_SIZE(BS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int tests = 0;
   int fails = 0;
   logic [FW-1:0] q [OUT][$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_model();
      for (int o = 0; o < OUT; o++) begin
         check($sformatf("valid[%0d]", o), 32'(bus.valid_o[o]), 32'(q[o].size() > 0));
         check($sformatf("full[%0d]", o), 32'(bus.full_o[o]), 32'(q[o].size() == BS));
         check($sformatf("data[%0d]", o), 32'(bus.data_o[o]),
               (q[o].size() > 0) ? 32'(q[o][0]) : 32'd0);
      end
   endtask

   // One clock: predict from current inputs and model, advance, then compare.
   task automatic step();
      bit            push [OUT];
      bit            pop  [OUT];
      logic [FW-1:0] d    [OUT];
      for (int o = 0; o < OUT; o++) begin
         int s;
         s       = int'(bus.sel_i[o]);
         push[o] = rst && bus.en_i[o] && (s < IN) && bus.valid_i[s] && (q[o].size() < BS);
         d[o]    = bus.data_i[s];
         pop[o]  = rst && (q[o].size() > 0) && bus.ready_i[o];
      end
      @(posedge clk);
      #1;
      for (int o = 0; o < OUT; o++) begin
         if (!rst) begin
            q[o].delete();
         end else begin
            if (pop[o])  void'(q[o].pop_front());
            if (push[o]) q[o].push_back(d[o]);
         end
      end
      check_model();
   endtask

   task automatic idle(input logic [OUT-1:0] rdy);
      bus.data_i  = '0;
      bus.valid_i = '0;
      bus.sel_i   = '0;
      bus.en_i    = '0;
      bus.ready_i = rdy;
   endtask

   task automatic rand_inputs();
      bus.data_i  = (IN*FW)'($urandom);
      bus.valid_i = IN'($urandom);
      bus.sel_i   = (OUT*SW)'($urandom);
      bus.en_i    = OUT'($urandom);
      bus.ready_i = OUT'($urandom);
   endtask

   task automatic drain();
      idle({OUT{1'b1}});
      for (int i = 0; i < BS + 1; i++) step();
   endtask

   int n;

   initial begin
      // 1. Reset held with random inputs, then async reset with data buffered.
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_inputs();
         #1;
         check("rst_hold_valid", 32'(bus.valid_o), 32'd0);
         check("rst_hold_full", 32'(bus.full_o), 32'd0);
         check("rst_hold_data", 32'(bus.data_o), 32'd0);
         step();
      end
      rst = 1'b1;
      idle({OUT{1'b0}});
      bus.data_i  = {4'h4, 4'h3, 4'h2, 4'h1};
      bus.valid_i = 4'hF;
      bus.sel_i   = {2'd3, 2'd2, 2'd1, 2'd0};
      bus.en_i    = 4'hF;
      step();
      step();
      check("prefill_full", 32'(bus.full_o), 32'hF);
      idle({OUT{1'b0}});
      #3;
      rst = 1'b0;
      #1;
      check("async_rst_valid", 32'(bus.valid_o), 32'd0);
      check("async_rst_full", 32'(bus.full_o), 32'd0);
      check("async_rst_data", 32'(bus.data_o), 32'd0);
      for (int o = 0; o < OUT; o++) q[o].delete();
      step();
      rst = 1'b1;
      bus.data_i[1]  = 4'h7;
      bus.valid_i[1] = 1'b1;
      bus.sel_i[2]   = 2'd1;
      bus.en_i[2]    = 1'b1;
      step();
      check("first_write_after_rst", 32'(bus.valid_o), 32'h4);
      drain();

      // 2. Unicast latency.
      idle({OUT{1'b1}});
      bus.data_i[2] = 4'hA;
      bus.valid_i   = 4'b0100;
      bus.sel_i[1]  = 2'd2;
      bus.en_i      = 4'b0010;
      step();
      check("uni_data", 32'(bus.data_o[1]), 32'hA);
      check("uni_valid", 32'(bus.valid_o), 32'h2);
      idle({OUT{1'b1}});
      step();
      check("uni_gone", 32'(bus.valid_o), 32'h0);

      // 3. Multicast of input 0 to every output.
      idle({OUT{1'b1}});
      bus.data_i[0] = 4'h5;
      bus.valid_i   = 4'b0001;
      bus.en_i      = 4'hF;
      step();
      check("mc_valid", 32'(bus.valid_o), 32'hF);
      check("mc_data", 32'(bus.data_o), 32'h5555);
      drain();

      // 4. Backpressure: third write to a full output is dropped.
      idle(4'b1110);
      bus.valid_i = 4'b0001;
      bus.en_i    = 4'b0001;
      bus.data_i[0] = 4'h1; step();
      check("bp_not_full", 32'(bus.full_o[0]), 32'd0);
      bus.data_i[0] = 4'h2; step();
      check("bp_full", 32'(bus.full_o[0]), 32'd1);
      bus.data_i[0] = 4'h3; step();
      check("bp_head_kept", 32'(bus.data_o[0]), 32'h1);
      idle({OUT{1'b1}});
      step();
      check("bp_second", 32'(bus.data_o[0]), 32'h2);
      check("bp_unfull", 32'(bus.full_o[0]), 32'd0);
      step();
      check("bp_empty", 32'(bus.valid_o[0]), 32'd0);

      // 5. Push+pop at full is refused; at count 1 it keeps the count.
      idle(4'b1110);
      bus.valid_i = 4'b0001;
      bus.en_i    = 4'b0001;
      bus.data_i[0] = 4'h8; step();
      bus.data_i[0] = 4'h9; step();
      bus.ready_i   = 4'hF;
      bus.data_i[0] = 4'hC; step();
      check("pp_full_head", 32'(bus.data_o[0]), 32'h9);
      check("pp_full_cnt1", 32'(bus.full_o[0]), 32'd0);
      bus.data_i[0] = 4'hD; step();
      check("pp_cnt1_head", 32'(bus.data_o[0]), 32'hD);
      check("pp_cnt1_valid", 32'(bus.valid_o[0]), 32'd1);
      check("pp_cnt1_notfull", 32'(bus.full_o[0]), 32'd0);
      drain();

      // 6. Stream 20 random flits through output 3; grant only when not full.
      n = 0;
      for (int c = 0; c < 400 && n < 20; c++) begin
         rand_inputs();
         bus.en_i = '0;
         if (q[3].size() < BS && $urandom_range(0, 3) != 0) begin
            bus.en_i[3] = 1'b1;
            bus.valid_i[bus.sel_i[3]] = 1'b1;
            n++;
         end
         step();
      end
      check("stream_count", 32'(n), 32'd20);
      drain();
      check("stream_drained", 32'(bus.valid_o[3]), 32'd0);

      // Fully random traffic, including grants to full outputs.
      for (int c = 0; c < 300; c++) begin
         rand_inputs();
         step();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/crossbar_buffered.md
# crossbar_buffered

Registered, flow-controlled successor to the combinational switch crossbar in the router datapath. Each output port has its own select, enable and a small FIFO, so switch traversal is decoupled from link traversal. Flits enter a per-output FIFO one cycle after selection and are drained under a valid/ready handshake with the downstream link. The block sits between switch allocation and the output links; `full_o` feeds back to the allocator.

## Interface
- `INPUT_NUM`, 4: number of input ports (≥2).
- `OUTPUT_NUM`, 4: number of output ports (≥1).
- `FLIT_SIZE`, 4: flit width in bits.
- `BUFFER_SIZE`, 2: per-output FIFO depth. Power of two, ≥2.
- `SEL_SIZE`, $clog2(INPUT_NUM): localparam, select width.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data_i`  in  [INPUT_NUM] × FLIT_SIZE  input flits.
- `valid_i`  in  INPUT_NUM  input flit valid.
- `sel_i`  in  [OUTPUT_NUM] × SEL_SIZE  input index routed to each output.
- `en_i`  in  OUTPUT_NUM  per-output switch grant.
- `data_o`  out  [OUTPUT_NUM] × FLIT_SIZE  FIFO head per output.
- `valid_o`  out  OUTPUT_NUM  FIFO non-empty.
- `ready_i`  in  OUTPUT_NUM  downstream accepts the head this cycle.
- `full_o`  out  OUTPUT_NUM  FIFO holds BUFFER_SIZE flits.

## Operation
- Output o writes when `en_i[o] && valid_i[sel_i[o]] && !full_o[o] && sel_i[o] < INPUT_NUM`.
  - Written data is `data_i[sel_i[o]]`.
  - If `sel_i[o] ≥ INPUT_NUM`, the write is dropped with no error.
- Output o pops when `valid_o[o] && ready_i[o]`.
- Multicast is legal: several outputs may select the same input in the same cycle, and each output FIFO captures its own copy.
- There is no per-input ready. The allocator must not grant an output whose `full_o` is high. A grant to a full output is discarded: the flit is lost and FIFO state is unchanged.
- FIFO structure:
  - Circular buffer with read pointer, write pointer and a counter of width $clog2(BUFFER_SIZE)+1.
  - Pointers wrap modulo BUFFER_SIZE.
- Full and simultaneous push/pop:
  - `full_o` is evaluated from the pre-pop count.
  - When full, a same-cycle push is refused even if a pop occurs. There is no write-through.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- Empty FIFO:
  - `valid_o = 0` and `data_o = 0`; data_o is forced to zero, not the stale head.
  - `ready_i` is ignored.
- Output ports are fully independent: there is no cross-output state.

## Timing
- Reset (`rst` low, asynchronous):
  - Pointers and counts go to 0.
  - `valid_o = 0`, `full_o = 0`, `data_o = 0` on all outputs.
  - Storage contents need not be cleared.
- Reset mid-operation: all buffered flits are discarded immediately. The first write after `rst` deasserts is accepted on the next rising edge.
- Latency: a flit written at edge N appears on `data_o` with `valid_o = 1` after edge N, i.e. one cycle, when the FIFO was empty.
- `data_o`, `valid_o` and `full_o` are decoded from registers only; there is no combinational path from `*_i` to any output.
- Throughput: one flit per cycle per output, sustained with `ready_i` held high.
- Backpressure: with `ready_i` low, an output accepts exactly BUFFER_SIZE flits, then `full_o` asserts on the edge that writes the last one.
- After one pop from full, `full_o` deasserts on the next edge.

## Test plan
All scenarios use default parameters.

1. **Reset:** hold `rst` low, drive random inputs. Outputs 0/0/0 throughout. Assert `rst` asynchronously mid-cycle while FIFOs hold data; `valid_o` drops before the next edge.
2. **Unicast latency:** set `data_i[2] = 4'hA`, `valid_i = 4'b0100`, `sel_i[1] = 2`, `en_i = 4'b0010` for one cycle, with `ready_i` high. One cycle later `data_o[1] = 4'hA` and `valid_o = 4'b0010`; the next cycle `valid_o = 0`.
3. **Multicast:** all outputs select input 0 carrying `4'h5`, `en_i = 4'hF`. All four `data_o = 4'h5` with `valid_o = 4'hF` after one cycle.
4. **Backpressure and full:** `ready_i[0] = 0`, write `4'h1`, then `4'h2`, then `4'h3` to output 0.
   - `full_o[0] = 1` after the second flit; the third is dropped.
   - Release `ready_i`: outputs `4'h1` then `4'h2`, then `valid_o[0] = 0`.
5. **Simultaneous push/pop at full:** output 0 holds 2 flits, pop and push in the same cycle. The push is refused; count becomes 1.
   - At count 1, push and pop together: count stays 1 and the new flit follows in order.
6. **Wrap-around and randomness:** stream 20 random flits through output 3 with `ready_i` toggling randomly, using a scoreboard. All flits arrive in order with no loss.
   - The allocator model never grants while `full_o` is high.
   - The pointers wrap several times.
